// File: rtl/fir_mac_pkg.sv
// rtl/fir_mac_pkg.sv - constants, types and Q15 scale/saturate helper for the FIR MAC slice
package fir_mac_pkg;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 32;
  localparam int FRAC_BITS = 15;
  localparam int Q_TOP     = FRAC_BITS + DATA_W - 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Bits above the Q field must all match the sign bit, otherwise clamp to full scale.
  function automatic sample_t sat_q15(input acc_t v);
    if (v[ACC_W-1:Q_TOP] != {(ACC_W-Q_TOP){v[ACC_W-1]}})
      return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return v[Q_TOP:FRAC_BITS];
  endfunction

endpackage

// File: rtl/fir_mac_alu_if.sv
// rtl/fir_mac_alu_if.sv - operand and result bundle between FIR control and the MAC slice
interface fir_mac_alu_if;
  import fir_mac_pkg::*;

  sample_t a;
  sample_t b;
  acc_t    acc_in;
  acc_t    mult_result;
  sample_t mult_result_16;
  acc_t    acc_out;
  sample_t acc_out_16;

  modport master (
    output a, b, acc_in,
    input  mult_result, mult_result_16, acc_out, acc_out_16
  );

  modport slave (
    input  a, b, acc_in,
    output mult_result, mult_result_16, acc_out, acc_out_16
  );
endinterface

// File: rtl/fir_mac_mult_stage.sv
// rtl/fir_mac_mult_stage.sv - registered signed multiply with Q15 output
module fir_mac_mult_stage
  import fir_mac_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t a,
  input  sample_t b,
  output acc_t    mult_result,
  output sample_t mult_result_16
);

  acc_t product;

  // Operands widened first so the full product lands in ACC_W bits.
  assign product = acc_t'(a) * acc_t'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_result    <= '0;
      mult_result_16 <= '0;
    end else begin
      mult_result    <= product;
      mult_result_16 <= sat_q15(product);
    end
  end

endmodule

// File: rtl/fir_mac_alu.sv
// rtl/fir_mac_alu.sv - two-stage multiply-accumulate slice of the FIR core
module fir_mac_alu
  import fir_mac_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fir_mac_alu_if.slave bus
);

  acc_t    mult_q;
  sample_t mult_q16;
  acc_t    acc_q;
  sample_t acc_q16;
  acc_t    acc_sum;

  fir_mac_mult_stage u_mult (
    .clk            (clk),
    .rst            (rst),
    .a              (bus.a),
    .b              (bus.b),
    .mult_result    (mult_q),
    .mult_result_16 (mult_q16)
  );

  // Wraps modulo 2^ACC_W; only the Q15 output saturates.
  assign acc_sum = bus.acc_in + mult_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      acc_q16 <= '0;
    end else begin
      acc_q   <= acc_sum;
      acc_q16 <= sat_q15(acc_sum);
    end
  end

  assign bus.mult_result    = mult_q;
  assign bus.mult_result_16 = mult_q16;
  assign bus.acc_out        = acc_q;
  assign bus.acc_out_16     = acc_q16;

endmodule

// File: tb/tb_fir_mac_alu.sv
// tb/tb_fir_mac_alu.sv - scoreboard bench for the FIR MAC slice
module tb_fir_mac_alu;
  import fir_mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_mac_alu_if bus();

  fir_mac_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mult_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] prev_prod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_q15(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s > 64'sh3FFF_FFFF)  return 16'h7FFF;
    if (s < -64'sh4000_0000) return 16'h8000;
    return 16'(s >>> 15);
  endfunction

  // One pipeline step: drive, predict, clock, then compare against the predictions.
  task automatic cycle(input int a, input int b, input logic [31:0] acc_in);
    logic [31:0] p;
    logic [31:0] em;
    logic [31:0] ea;
    bus.a      = sample_t'(a);
    bus.b      = sample_t'(b);
    bus.acc_in = acc_in;
    p = 32'(longint'(a) * longint'(b));
    mult_q.push_back(p);
    acc_q.push_back(32'(longint'(acc_in) + longint'(prev_prod)));
    prev_prod = p;
    @(posedge clk);
    #1;
    em = mult_q.pop_front();
    ea = acc_q.pop_front();
    check("sb_mult", bus.mult_result, em);
    check("sb_mult16", {bus.mult_result_16}, {16'h0, model_q15(em)});
    check("sb_acc", bus.acc_out, ea);
    check("sb_acc16", {bus.acc_out_16}, {16'h0, model_q15(ea)});
    @(negedge clk);
  endtask

  initial begin
    bus.a      = '0;
    bus.b      = '0;
    bus.acc_in = '0;
    prev_prod  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mult", bus.mult_result, 32'h0);
    check("rst_acc", bus.acc_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    cycle(10, 5, 32'd0);
    check("basic_mult", bus.mult_result, 32'd50);
    check("basic_mult16", {bus.mult_result_16}, 32'd0);
    cycle(7, 3, 32'd0);
    check("basic_acc", bus.acc_out, 32'd50);
    check("chain_mult", bus.mult_result, 32'd21);
    cycle(1024, 2048, 32'd50);
    check("chain_acc", bus.acc_out, 32'd71);
    check("big_mult", bus.mult_result, 32'd2097152);
    check("big_mult16", {bus.mult_result_16}, 32'd64);
    cycle(-32768, -32768, 32'd71);
    check("big_acc", bus.acc_out, 32'd2097223);
    check("big_acc16", {bus.acc_out_16}, 32'd64);
    check("neg_neg_mult", bus.mult_result, 32'h4000_0000);
    check("neg_neg_mult16", {bus.mult_result_16}, 32'h7FFF);
    cycle(-32768, 32767, 32'h7FFF_FFFF);
    check("wrap_acc", bus.acc_out, 32'hBFFF_FFFF);
    check("wrap_acc16", {bus.acc_out_16}, 32'h8000);
    check("neg_pos_mult", bus.mult_result, 32'hC000_8000);
    check("neg_pos_mult16", {bus.mult_result_16}, 32'h8001);
    cycle(0, 0, 32'd0);
    check("carry_acc", bus.acc_out, 32'hC000_8000);

    for (int i = 0; i < 1000; i++)
      cycle(int'(sample_t'($urandom())), int'(sample_t'($urandom())), $urandom());

    // Asynchronous reset in mid-stream with a=10, b=5 still applied.
    cycle(10, 5, 32'd20);
    rst = 1'b1;
    #1;
    check("arst_mult", bus.mult_result, 32'h0);
    check("arst_mult16", {bus.mult_result_16}, 32'h0);
    check("arst_acc", bus.acc_out, 32'h0);
    check("arst_acc16", {bus.acc_out_16}, 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold_mult", bus.mult_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev_prod = '0;
    cycle(10, 5, 32'd20);
    check("post_rst_mult", bus.mult_result, 32'd50);
    cycle(10, 5, 32'd20);
    check("post_rst_acc", bus.acc_out, 32'd70);

    for (int i = 0; i < 50; i++)
      cycle(int'(sample_t'($urandom())), int'(sample_t'($urandom())), $urandom());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
